// File: rtl/cp0_intc_if.sv
// CPU <-> CP0 interrupt-controller bus: mfc0/mtc0 access, commit-stage victim info,
// device interrupt lines and the trap request back to the pipeline.
interface cp0_intc_if;
  logic [4:0]  rd_sel;
  logic [4:0]  wr_sel;
  logic [31:0] din;
  logic        we;
  logic [31:0] pc;
  logic        bd;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic        eret;
  logic [5:0]  HWInt;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] dout;

  modport master (
    output rd_sel, wr_sel, din, we, pc, bd, exc_req, exc_code, eret, HWInt,
    input  IntReq, EPC, dout
  );

  modport slave (
    input  rd_sel, wr_sel, din, we, pc, bd, exc_req, exc_code, eret, HWInt,
    output IntReq, EPC, dout
  );
endinterface

// File: rtl/cp0_intc.sv
// Coprocessor-0 interrupt/exception controller: holds SR/Cause/EPC/PRId and raises
// IntReq whenever the committing instruction must be replaced by a trap.
module cp0_intc #(
  parameter logic [31:0] PRID = 32'h0000_B7A0
) (
  input  logic       clk,
  input  logic       reset,
  cp0_intc_if.slave  bus
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc;
  logic [31:2] r_epc;

  logic        w_int_pend;
  logic        w_exc_pend;
  logic        w_trap;
  logic        w_wr_sr;
  logic        w_wr_epc;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic [31:0] w_epc;
  logic        w_unused_pc;

  // Interrupts are judged on the registered IP copy, never on raw HWInt.
  assign w_int_pend = (|(r_ip & r_im)) & r_ie & ~r_exl;
  assign w_exc_pend = bus.exc_req & ~r_exl;
  assign w_trap     = w_int_pend | w_exc_pend;

  assign w_wr_sr  = bus.we && (bus.wr_sel == 5'd12);
  assign w_wr_epc = bus.we && (bus.wr_sel == 5'd14);

  assign w_sr        = {16'b0, r_im, 8'b0, r_exl, r_ie};
  assign w_cause     = {r_bd, 15'b0, r_ip, 3'b0, r_exc, 2'b0};
  assign w_epc       = {r_epc, 2'b00};
  assign w_unused_pc = ^bus.pc[1:0];

  assign bus.IntReq = w_trap;
  assign bus.EPC    = w_epc;

  // NOTE: state registers use non-blocking assignments so every branch below sees
  // the pre-edge values and a later assignment in the block cleanly overrides an earlier one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_im  <= '0;
      r_exl <= 1'b0;
      r_ie  <= 1'b0;
      r_bd  <= 1'b0;
      r_ip  <= '0;
      r_exc <= '0;
      r_epc <= '0;
    end else begin
      r_ip <= bus.HWInt;
      if (w_trap) begin
        // The victim is flushed, so any mtc0/eret it carried is dropped.
        r_exl <= 1'b1;
        r_exc <= w_int_pend ? 5'd0 : bus.exc_code;
        r_bd  <= bus.bd;
        r_epc <= bus.bd ? (bus.pc[31:2] - 30'd1) : bus.pc[31:2];
      end else begin
        if (w_wr_sr) begin
          r_im  <= bus.din[15:10];
          r_exl <= bus.din[1];
          r_ie  <= bus.din[0];
        end
        if (bus.eret) r_exl <= 1'b0;
        if (w_wr_epc) r_epc <= bus.din[31:2];
      end
    end
  end

  // NOTE: the default assignment ahead of the case keeps this purely combinational (no latch).
  always_comb begin
    bus.dout = 32'd0;
    case (bus.rd_sel)
      5'd12:   bus.dout = w_sr;
      5'd13:   bus.dout = w_cause;
      5'd14:   bus.dout = w_epc;
      5'd15:   bus.dout = PRID;
      default: bus.dout = 32'd0;
    endcase
  end

endmodule

// File: doc/cp0_intc.md
Name: cp0_intc

Overview:
- Coprocessor-0 interrupt/exception controller. Sits directly downstream of the bus-mapped devices (timers etc.).
- Consumes their IntReq lines as HWInt[7:2], holds SR/Cause/EPC/PRId, and decides each cycle whether the CPU pipeline must trap.
- The CPU reads and writes it through mfc0/mtc0 and returns from the handler through eret.

Parameters:
- PRID, 32'h0000_B7A0, constant value returned for register 15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset: low clears all state immediately, independent of clk.
- rd_sel  input  5  CP0 register index for mfc0 read.
- wr_sel  input  5  CP0 register index for mtc0 write.
- din  input  32  mtc0 write data.
- we  input  1  mtc0 write enable.
- pc  input  32  PC of the instruction in the commit stage (victim PC).
- bd  input  1  victim instruction is in a branch delay slot.
- exc_req  input  1  synchronous exception raised by the victim instruction.
- exc_code  input  5  code for exc_req (4 AdEL, 5 AdES, 10 RI, 12 Ov).
- eret  input  1  eret commits this cycle.
- HWInt  input  6  device interrupt lines [7:2]; bit 2 = DEV_0 IntReq, bit 3 = DEV_1 IntReq, others external.
- IntReq  output  1  trap now: flush the pipeline and fetch from the handler entry.
- EPC  output  32  current EPC register value (eret target).
- dout  output  32  mfc0 read data.

Behaviour:
- Registers:
  - SR(12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC(14): 32 bits, bits [1:0] always 0.
  - PRId(15): PRID.
- Reset (reset=0, asynchronous): SR=0, Cause=0, EPC=0. Hence IntReq=0, EPC=0, dout=0 for rd_sel 12/13/14.
- IP sampling: Cause.IP <= HWInt on every rising edge, regardless of EXL/IE. IP is a registered copy with one cycle of latency; devices hold their level request, so nothing is lost.
- Interrupt request: int_pend = |(Cause.IP & SR.IM) & SR.IE & !SR.EXL. Uses the registered IP, not raw HWInt.
- Exception request: exc_pend = exc_req & !SR.EXL.
- IntReq = int_pend | exc_pend. Purely combinational from registered state plus exc_req.
- Trap edge (IntReq=1 at rising edge):
  - SR.EXL <= 1.
  - Cause.ExcCode <= int_pend ? 0 : exc_code. Interrupts have priority over a simultaneous exception.
  - Cause.BD <= bd.
  - EPC <= bd ? {pc[31:2],2'b00} - 4 : {pc[31:2],2'b00}.
  - Any mtc0 in the same cycle is discarded, because the victim is flushed.
- eret (IntReq=0): SR.EXL <= 0 at the edge. eret and IntReq together cannot occur, since EXL=1 masks IntReq. If both are forced, the trap wins.
- mtc0 (we=1, IntReq=0):
  - wr_sel=12: IM <= din[15:10], EXL <= din[1], IE <= din[0].
  - wr_sel=14: EPC <= {din[31:2],2'b00}.
  - wr_sel=13, wr_sel=15 and other indices: ignored.
  - mtc0 SR together with eret: the EXL value from eret wins; IM and IE still take din.
- mfc0: dout is combinational from rd_sel: 12 SR, 13 Cause, 14 EPC, 15 PRId, any other index 0. A read and write in the same cycle return the old value; no bypass.
- Nesting: while EXL=1 no interrupt or exception is accepted. Pending device lines stay visible in Cause.IP and are taken one cycle after eret clears EXL, if still enabled.
- Reset mid-handler: EXL, EPC and IM are cleared immediately, and IntReq drops within the same cycle.

Test Plan:
- Reset low with HWInt=6'h3F -> IntReq=0, dout(12)=0. After release, next edge: dout(13)=32'h0000_FC00, IntReq stays 0 (IE=0).
- mtc0 SR din=32'h0000_0401, then HWInt[2]=1 held, pc=32'h0000_3010, bd=0 -> IntReq=1 one cycle after IP sampled. After the edge: EXL=1, EPC=32'h0000_3010, ExcCode=0, IntReq=0.
- Same setup with bd=1, pc=32'h0000_3014 -> EPC=32'h0000_3010, Cause bit 31=1.
- exc_req=1, exc_code=12 with SR=0 -> IntReq=1; ExcCode=12 (dout(13)[6:2]=5'd12). Same cycle with an enabled pending interrupt -> ExcCode=0.
- In the handler (EXL=1), HWInt[3]=1 with IM[11]=1 -> IntReq=0. After eret, the next cycle gives IntReq=1 and EPC updates to the new pc.
- mtc0 wr_sel=13 din=32'hFFFF_FFFF -> Cause unchanged. wr_sel=14 din=32'h0000_3007 -> EPC=32'h0000_3004. rd_sel=15 -> 32'h0000_B7A0.
